// File: rtl/tdc_incr_scheduler.sv
// Round-robin arbiter sharing one fixed-latency "+1" datapath between N_CH TDC channels.
// Latency: grant in IDLE cycle t, dp_enable at t+1, ack/result at t+L+2 (L = datapath latency).
// Backpressure: requests are level-held by the channels and arbitrated at the next IDLE; none dropped.
//
// Ports:
//   clk100, rst            clock, asynchronous active-high reset
//   req, req_data          per-channel level request and packed operands
//   ack, result, result_ch one-cycle one-hot completion, returned data, served channel index
//   err, timeout_cnt       timeout flag (valid with ack), saturating timeout count
//   busy                   high whenever the scheduler is not idle
//   dp_enable, dp_data     start strobe and held operand to the shared datapath
//   dp_done, dp_result     datapath completion strobe and output
module tdc_incr_scheduler #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk100,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req,
  input  logic [N_CH*DATA_WIDTH-1:0] req_data,
  output logic [N_CH-1:0]            ack,
  output logic [DATA_WIDTH-1:0]      result,
  output logic [CH_W-1:0]            result_ch,
  output logic                       err,
  output logic                       busy,
  output logic [7:0]                 timeout_cnt,
  output logic                       dp_enable,
  output logic [DATA_WIDTH-1:0]      dp_data,
  input  logic                       dp_done,
  input  logic [DATA_WIDTH-1:0]      dp_result
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [CH_W-1:0]       ptr;
  logic [CNT_W-1:0]      wait_cnt;

  logic [N_CH-1:0]       rot_req;
  logic [CH_W:0]         cand;
  logic                  found;
  logic [CH_W-1:0]       grant;
  logic [CH_W:0]         ptr_inc;
  logic [CH_W-1:0]       next_ptr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Rotate requests so bit 0 is the channel at ptr; the lowest set bit of the
  // rotated vector is the round-robin winner, mapped back by adding ptr mod N_CH.
  always_comb begin
    rot_req = N_CH'({req, req} >> ptr);
    found   = 1'b0;
    grant   = '0;
    cand    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && rot_req[i]) begin
        found = 1'b1;
        cand  = {1'b0, ptr} + (CH_W+1)'(i);
        if (cand >= (CH_W+1)'(N_CH)) begin
          cand = cand - (CH_W+1)'(N_CH);
        end
        grant = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc  = {1'b0, grant} + 1'b1;
    next_ptr = (ptr_inc >= (CH_W+1)'(N_CH)) ? '0 : ptr_inc[CH_W-1:0];
  end

  // Operand mux with constant part-select bases.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CH_W'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wait_cnt    <= '0;
      result      <= '0;
      result_ch   <= '0;
      err         <= 1'b0;
      timeout_cnt <= '0;
      dp_data     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            result_ch <= grant;
            dp_data   <= sel_data;
            ptr       <= next_ptr;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (dp_done) begin
            result <= dp_result;
            err    <= 1'b0;
            state  <= S_DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT-1)) begin
            result <= '0;
            err    <= 1'b1;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            state  <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from state so reset clears them immediately.
  assign busy      = (state != S_IDLE);
  assign dp_enable = (state == S_ISSUE);

  always_comb begin
    ack = '0;
    for (int i = 0; i < N_CH; i++) begin
      ack[i] = (state == S_DONE) && (result_ch == CH_W'(i));
    end
  end

endmodule

// File: tb/tb_tdc_incr_scheduler.sv
module tb_tdc_incr_scheduler;

  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic              clk100 = 1'b0;
  logic              rst    = 1'b1;
  logic [N_CH-1:0]   req    = '0;
  logic [N_CH*DW-1:0] req_data;
  logic [N_CH-1:0]   ack;
  logic [DW-1:0]     result;
  logic [1:0]        result_ch;
  logic              err;
  logic              busy;
  logic [7:0]        timeout_cnt;
  logic              dp_enable;
  logic [DW-1:0]     dp_data;
  logic              dp_done;
  logic [DW-1:0]     dp_result;

  logic [DW-1:0]     rd [N_CH];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign req_data[g*DW +: DW] = rd[g];
  end

  tdc_incr_scheduler #(.N_CH(N_CH), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk100(clk100), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .result(result), .result_ch(result_ch), .err(err),
    .busy(busy), .timeout_cnt(timeout_cnt), .dp_enable(dp_enable),
    .dp_data(dp_data), .dp_done(dp_done), .dp_result(dp_result)
  );

  always #5 clk100 = ~clk100;

  always @(posedge clk100) cyc = cyc + 1;

  // Datapath model: returns operand+1, dp_done exactly dp_latency cycles after the enable cycle.
  int          dp_latency = 3;
  bit          dp_mute    = 1'b0;
  int          dp_cd      = 0;
  logic [DW-1:0] dp_op;

  initial begin
    dp_done   = 1'b0;
    dp_result = '0;
    dp_op     = '0;
    forever begin
      @(posedge clk100);
      #1;
      dp_done = 1'b0;
      if (dp_cd > 0) begin
        dp_cd = dp_cd - 1;
        if (dp_cd == 0 && !dp_mute) begin
          dp_done   = 1'b1;
          dp_result = dp_op + 1;
        end
      end
      if (dp_enable) begin
        dp_cd = dp_latency;
        dp_op = dp_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk100);
    #2;
  endtask

  task automatic reset_dut();
    next_cycle();
    rst     = 1'b1;
    req     = '0;
    dp_cd   = 0;
    dp_mute = 1'b0;
    dp_done = 1'b0;
    repeat (2) @(posedge clk100);
    #2;
    rst = 1'b0;
  endtask

  // Runs until the first ack (sampled mid-cycle) or the cycle budget expires (ack_c = -1).
  task automatic wait_ack(input int max_cyc, output int en_c, output int ack_c,
                          output logic [N_CH-1:0] ack_v, output logic [DW-1:0] res_v,
                          output logic [1:0] ch_v, output logic err_v);
    en_c = -1; ack_c = -1; ack_v = '0; res_v = '0; ch_v = '0; err_v = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk100);
      if (dp_enable && en_c < 0) en_c = cyc;
      if (ack != '0) begin
        ack_c = cyc; ack_v = ack; res_v = result; ch_v = result_ch; err_v = err;
        return;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    @(negedge clk100);
    tests++; if (ack !== 4'b0)        begin fails++; $display("FAIL reset_ack: got %h want 0", ack); end
    tests++; if (result !== 32'b0)    begin fails++; $display("FAIL reset_result: got %h want 0", result); end
    tests++; if (result_ch !== 2'b0)  begin fails++; $display("FAIL reset_result_ch: got %0d want 0", result_ch); end
    tests++; if (err !== 1'b0)        begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (timeout_cnt !== 8'b0) begin fails++; $display("FAIL reset_timeout_cnt: got %0d want 0", timeout_cnt); end
    tests++; if (dp_enable !== 1'b0)  begin fails++; $display("FAIL reset_dp_enable: got %b want 0", dp_enable); end
    tests++; if (dp_data !== 32'b0)   begin fails++; $display("FAIL reset_dp_data: got %h want 0", dp_data); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single();
    int en_c, ack_c, t; logic [N_CH-1:0] av; logic [DW-1:0] rv; logic [1:0] cv; logic ev;
    dp_latency = 3;
    rd[0] = 32'h0000_00FF;
    req   = 4'b0001;
    t     = cyc;
    wait_ack(40, en_c, ack_c, av, rv, cv, ev);
    tests++; if (en_c != t+1)  begin fails++; $display("FAIL single_enable_cycle: got %0d want %0d", en_c, t+1); end
    tests++; if (ack_c != t+5) begin fails++; $display("FAIL single_ack_cycle: got %0d want %0d", ack_c, t+5); end
    tests++; if (av !== 4'b0001) begin fails++; $display("FAIL single_ack: got %b want 0001", av); end
    tests++; if (rv !== 32'h0000_0100) begin fails++; $display("FAIL single_result: got %h want 00000100", rv); end
    tests++; if (cv !== 2'd0)  begin fails++; $display("FAIL single_result_ch: got %0d want 0", cv); end
    tests++; if (ev !== 1'b0)  begin fails++; $display("FAIL single_err: got %b want 0", ev); end
    next_cycle();
    req = '0;
    @(negedge clk100);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int en_c, ack_c, prev; logic [N_CH-1:0] av; logic [DW-1:0] rv, ex; logic [1:0] cv; logic ev;
    reset_dut();
    dp_latency = 3;
    for (int k = 0; k < N_CH; k++) rd[k] = $urandom;
    req  = 4'b1111;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, en_c, ack_c, av, rv, cv, ev);
      ex = rd[k % N_CH] + 1;
      tests++; if (cv !== 2'(k % N_CH)) begin fails++; $display("FAIL rr_order[%0d]: got ch %0d want %0d", k, cv, k % N_CH); end
      tests++; if (rv !== ex) begin fails++; $display("FAIL rr_result[%0d]: got %h want %h", k, rv, ex); end
      if (k > 0) begin
        tests++; if (ack_c - prev != 6) begin fails++; $display("FAIL rr_spacing[%0d]: got %0d want 6", k, ack_c - prev); end
      end
      prev = ack_c;
      next_cycle();
    end
    req = '0;
    repeat (8) next_cycle();
  endtask

  task automatic test_pointer_wrap();
    int en_c, ack_c; logic [N_CH-1:0] av; logic [DW-1:0] rv; logic [1:0] cv; logic ev;
    reset_dut();
    rd[0] = 32'h1234_5678; rd[3] = 32'hFFFF_FFFF;
    req = 4'b1000;
    wait_ack(40, en_c, ack_c, av, rv, cv, ev);
    tests++; if (cv !== 2'd3) begin fails++; $display("FAIL wrap_first: got ch %0d want 3", cv); end
    tests++; if (rv !== 32'h0) begin fails++; $display("FAIL wrap_allones_result: got %h want 0", rv); end
    next_cycle();
    req = 4'b1001;
    wait_ack(40, en_c, ack_c, av, rv, cv, ev);
    tests++; if (cv !== 2'd0) begin fails++; $display("FAIL wrap_next: got ch %0d want 0", cv); end
    tests++; if (av !== 4'b0001) begin fails++; $display("FAIL wrap_ack: got %b want 0001", av); end
    next_cycle();
    req = 4'b1000;
    wait_ack(40, en_c, ack_c, av, rv, cv, ev);
    tests++; if (cv !== 2'd3) begin fails++; $display("FAIL wrap_third: got ch %0d want 3", cv); end
    next_cycle();
    req = '0;
    next_cycle();
  endtask

  task automatic test_timeout();
    int en_c, ack_c, t; logic [N_CH-1:0] av; logic [DW-1:0] rv; logic [1:0] cv; logic ev;
    reset_dut();
    dp_latency = 3;
    dp_mute = 1'b1;
    rd[0] = 32'h0000_0042;
    req = 4'b0001;
    t = cyc;
    wait_ack(60, en_c, ack_c, av, rv, cv, ev);
    tests++; if (ack_c != t+TO+2) begin fails++; $display("FAIL timeout_cycle: got %0d want %0d", ack_c, t+TO+2); end
    tests++; if (ev !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", ev); end
    tests++; if (rv !== 32'h0) begin fails++; $display("FAIL timeout_result: got %h want 0", rv); end
    tests++; if (timeout_cnt !== 8'd1) begin fails++; $display("FAIL timeout_cnt: got %0d want 1", timeout_cnt); end
    next_cycle();
    dp_mute = 1'b0;
    rd[1] = 32'h0000_0AAA;
    req = 4'b0010;
    t = cyc;
    wait_ack(40, en_c, ack_c, av, rv, cv, ev);
    tests++; if (ack_c != t+5) begin fails++; $display("FAIL after_timeout_cycle: got %0d want %0d", ack_c, t+5); end
    tests++; if (ev !== 1'b0) begin fails++; $display("FAIL after_timeout_err: got %b want 0", ev); end
    tests++; if (rv !== 32'h0000_0AAB) begin fails++; $display("FAIL after_timeout_result: got %h want 00000aab", rv); end
    tests++; if (timeout_cnt !== 8'd1) begin fails++; $display("FAIL after_timeout_cnt: got %0d want 1", timeout_cnt); end
    next_cycle();
    req = '0;
    next_cycle();
  endtask

  task automatic test_spurious_done();
    int en_c, ack_c, t; logic [N_CH-1:0] av; logic [DW-1:0] rv; logic [1:0] cv; logic ev;
    reset_dut();
    dp_latency = 4;
    dp_done = 1'b1; dp_result = 32'hDEAD_BEEF;
    @(negedge clk100);
    tests++; if (busy !== 1'b0 || ack !== 4'b0) begin fails++; $display("FAIL idle_done_pulse: busy %b ack %b want 0 0", busy, ack); end
    next_cycle();
    @(negedge clk100);
    tests++; if (busy !== 1'b0 || ack !== 4'b0 || result !== 32'h0) begin
      fails++; $display("FAIL idle_done_after: busy %b ack %b result %h want 0 0 0", busy, ack, result);
    end
    next_cycle();
    rd[1] = 32'h0000_7FFF;
    req = 4'b0010;
    t = cyc;
    next_cycle();
    dp_done = 1'b1; dp_result = 32'hBAD0_BAD0;
    wait_ack(40, en_c, ack_c, av, rv, cv, ev);
    tests++; if (en_c != t+1) begin fails++; $display("FAIL early_enable_cycle: got %0d want %0d", en_c, t+1); end
    tests++; if (ack_c != t+6) begin fails++; $display("FAIL early_ack_cycle: got %0d want %0d", ack_c, t+6); end
    tests++; if (rv !== 32'h0000_8000) begin fails++; $display("FAIL early_result: got %h want 00008000", rv); end
    tests++; if (cv !== 2'd1 || ev !== 1'b0) begin fails++; $display("FAIL early_ch_err: got ch %0d err %b want 1 0", cv, ev); end
    next_cycle();
    req = '0;
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    int en_c, ack_c, bad; logic [N_CH-1:0] av; logic [DW-1:0] rv; logic [1:0] cv; logic ev;
    reset_dut();
    dp_latency = 10;
    rd[2] = 32'h0000_0005;
    req = 4'b0100;
    repeat (4) next_cycle();
    @(negedge clk100);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midwait_busy_before: got %b want 1", busy); end
    next_cycle();
    rst = 1'b1;
    req = '0;
    #1;
    tests++; if (busy !== 1'b0 || ack !== 4'b0 || dp_enable !== 1'b0) begin
      fails++; $display("FAIL midwait_strobes: busy %b ack %b en %b want 0", busy, ack, dp_enable);
    end
    tests++; if (dp_data !== 32'h0 || result_ch !== 2'd0 || result !== 32'h0 || err !== 1'b0) begin
      fails++; $display("FAIL midwait_data: dp_data %h ch %0d result %h err %b want 0", dp_data, result_ch, result, err);
    end
    repeat (2) next_cycle();
    rst = 1'b0;
    next_cycle();
    dp_done = 1'b1; dp_result = 32'h5555_5555;
    bad = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk100);
      if (ack !== 4'b0 || busy !== 1'b0) bad++;
      next_cycle();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midwait_no_ack: got %0d active cycles want 0", bad); end
    rd[1] = 32'h0000_0010; rd[3] = 32'h0000_0030;
    dp_latency = 2;
    req = 4'b1010;
    wait_ack(40, en_c, ack_c, av, rv, cv, ev);
    tests++; if (cv !== 2'd1) begin fails++; $display("FAIL midwait_ptr_reset: got ch %0d want 1", cv); end
    tests++; if (rv !== 32'h0000_0011) begin fails++; $display("FAIL midwait_next_result: got %h want 00000011", rv); end
    next_cycle();
    req = '0;
    next_cycle();
  endtask

  // Transaction-level reference: when the scheduler is idle at cycle c and some
  // request is up, the winner is the first set channel at or after the pointer;
  // its ack lands at c+L+2 with operand+1, and the scheduler is idle again one cycle later.
  task automatic test_random(input int lat, input int ncyc);
    int rptr, idle_at, ack_at, g, c, k;
    bit have, got;
    logic [N_CH-1:0] lower, exp_ack;
    logic [DW-1:0]   exp_res;
    logic            exp_busy;
    reset_dut();
    dp_latency = lat;
    rptr = 0; idle_at = cyc; have = 1'b0; lower = '0; g = 0; ack_at = -1; exp_res = '0;
    for (int n = 0; n < ncyc; n++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (lower[ch]) begin
          req[ch] = 1'b0; lower[ch] = 1'b0;
        end else if (!req[ch] && $urandom_range(0, 3) == 0) begin
          rd[ch]  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          req[ch] = 1'b1;
        end
      end
      @(negedge clk100);
      c = cyc;
      exp_busy = (c != idle_at);
      if (c == idle_at) begin
        if (req != '0) begin
          got = 1'b0;
          for (int i = 0; i < N_CH; i++) begin
            k = (rptr + i) % N_CH;
            if (!got && req[k]) begin got = 1'b1; g = k; end
          end
          exp_res = rd[g] + 1;
          ack_at  = c + lat + 2;
          rptr    = (g + 1) % N_CH;
          idle_at = ack_at + 1;
          have    = 1'b1;
        end else begin
          idle_at = c + 1;
        end
      end
      exp_ack = '0;
      if (have && c == ack_at) exp_ack[g] = 1'b1;
      tests++; if (ack !== exp_ack) begin fails++; $display("FAIL rand_ack L%0d cyc %0d: got %b want %b", lat, c, ack, exp_ack); end
      tests++; if (busy !== exp_busy) begin fails++; $display("FAIL rand_busy L%0d cyc %0d: got %b want %b", lat, c, busy, exp_busy); end
      if (exp_ack != '0) begin
        tests++; if (result !== exp_res) begin fails++; $display("FAIL rand_result L%0d cyc %0d: got %h want %h", lat, c, result, exp_res); end
        tests++; if (result_ch !== 2'(g) || err !== 1'b0) begin
          fails++; $display("FAIL rand_ch_err L%0d cyc %0d: got ch %0d err %b want ch %0d err 0", lat, c, result_ch, err, g);
        end
        lower[g] = 1'b1;
        have = 1'b0;
      end
      next_cycle();
    end
    req = '0;
    repeat (lat + 4) next_cycle();
  endtask

  initial begin
    for (int k = 0; k < N_CH; k++) rd[k] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_spurious_done();
    test_reset_mid_wait();
    test_random(1, 300);
    test_random(2, 300);
    test_random(5, 300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
